// File: rtl/demo_de0_sys_st_pkg.sv
// Shared constants and helpers for the demo_de0_sys Avalon-ST adapters.
package demo_de0_sys_st_pkg;

   localparam int unsigned ST_RL_MAX             = 4;
   localparam int unsigned ST_DATA_WIDTH_DEFAULT = 32;

   // Occupancy counter must represent 0..depth inclusive.
   function automatic int unsigned st_fill_width(input int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/demo_de0_sys_st_rl_fifo.sv
// Synchronous register-based FIFO with head read, occupancy count and full/empty flags.
module demo_de0_sys_st_rl_fifo
   import demo_de0_sys_st_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = ST_DATA_WIDTH_DEFAULT,
   parameter int unsigned DEPTH      = 4,
   parameter int unsigned FILL_WIDTH = st_fill_width(DEPTH)
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] push_data,
   input  logic                  pop,
   output logic [DATA_WIDTH-1:0] head_data,
   output logic [FILL_WIDTH-1:0] fill_level,
   output logic                  full,
   output logic                  empty
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [FILL_WIDTH-1:0] fill_q, fill_d;
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] mem_d [DEPTH];

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      fill_d   = fill_q;
      if (push) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({push, pop})
         2'b10:   fill_d = fill_q + FILL_WIDTH'(1);
         2'b01:   fill_d = fill_q - FILL_WIDTH'(1);
         default: fill_d = fill_q;
      endcase
   end

   // Storage is cleared on reset so the head reads as zero after reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         fill_q   <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         fill_q   <= fill_d;
         mem_q    <= mem_d;
      end
   end

   assign head_data  = mem_q[rd_ptr_q];
   assign fill_level = fill_q;
   assign full       = (fill_q == FILL_WIDTH'(DEPTH));
   assign empty      = (fill_q == '0);

endmodule

// File: rtl/demo_de0_sys_st_ready_latency_adapter.sv
// Adapts a ready-latency-0 Avalon-ST source to a sink with READY_LATENCY 1..4,
// buffering beats in a small FIFO so both handshakes decode from registers only.
module demo_de0_sys_st_ready_latency_adapter
   import demo_de0_sys_st_pkg::*;
#(
   parameter int unsigned DATA_WIDTH    = ST_DATA_WIDTH_DEFAULT,
   parameter int unsigned READY_LATENCY = 2,
   parameter int unsigned FIFO_DEPTH    = 4,
   parameter int unsigned FILL_WIDTH    = st_fill_width(FIFO_DEPTH)
) (
   input  logic                  clk,
   input  logic                  reset_n,
   output logic                  in_ready,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  out_ready,
   output logic                  out_valid,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [FILL_WIDTH-1:0] fill_level
);

   if (READY_LATENCY < 1 || READY_LATENCY > ST_RL_MAX) begin : g_bad_rl
      $error("READY_LATENCY out of range");
   end

   logic                     run_q, run_d;
   logic [READY_LATENCY-1:0] ready_pipe_q, ready_pipe_d;
   logic                     ready_d;
   logic                     push, pop;
   logic                     full, empty;

   always_comb begin
      run_d           = 1'b1;
      ready_pipe_d    = '0;
      ready_pipe_d[0] = out_ready;
      for (int unsigned i = 1; i < READY_LATENCY; i++) begin
         ready_pipe_d[i] = ready_pipe_q[i-1];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         run_q        <= 1'b0;
         ready_pipe_q <= '0;
      end else begin
         run_q        <= run_d;
         ready_pipe_q <= ready_pipe_d;
      end
   end

   // Oldest stage: out_ready as sampled READY_LATENCY cycles ago grants this cycle's slot.
   assign ready_d   = ready_pipe_q[READY_LATENCY-1];
   assign in_ready  = run_q & ~full;
   assign out_valid = ready_d & ~empty;
   assign push      = in_valid & in_ready;
   assign pop       = out_valid;

   demo_de0_sys_st_rl_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (FIFO_DEPTH),
      .FILL_WIDTH (FILL_WIDTH)
   ) u_fifo (
      .clk        (clk),
      .reset_n    (reset_n),
      .push       (push),
      .push_data  (in_data),
      .pop        (pop),
      .head_data  (out_data),
      .fill_level (fill_level),
      .full       (full),
      .empty      (empty)
   );

endmodule

// File: tb/tb_demo_de0_sys_st_ready_latency_adapter.sv
// Directed bench for the RL0 -> RL2 adapter: vector table plus hand-written corner sequences.
module tb_demo_de0_sys_st_ready_latency_adapter;

   logic        clk;
   logic        reset_n;
   logic        in_ready;
   logic        in_valid;
   logic [31:0] in_data;
   logic        out_ready;
   logic        out_valid;
   logic [31:0] out_data;
   logic [2:0]  fill_level;

   int unsigned check_count = 0;
   int unsigned pass_count  = 0;

   demo_de0_sys_st_ready_latency_adapter #(
      .DATA_WIDTH    (32),
      .READY_LATENCY (2),
      .FIFO_DEPTH    (4),
      .FILL_WIDTH    (3)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .in_ready   (in_ready),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .out_ready  (out_ready),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .fill_level (fill_level)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   typedef struct {
      logic        iv;
      logic [31:0] d;
      logic        ordy;
      logic        e_ir;
      logic        e_ov;
      logic [31:0] e_data;
      int unsigned e_fill;
   } vec_t;

   vec_t vecs [18];

   function automatic vec_t mk(input logic iv, input logic [31:0] d, input logic ordy,
                               input logic e_ir, input logic e_ov, input logic [31:0] e_data,
                               input int unsigned e_fill);
      vec_t v;
      v.iv = iv; v.d = d; v.ordy = ordy;
      v.e_ir = e_ir; v.e_ov = e_ov; v.e_data = e_data; v.e_fill = e_fill;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      check_count++;
      if (act === exp) begin
         pass_count++;
      end else begin
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Drive inputs for the current cycle (called at a negedge) and advance one cycle.
   task automatic tick(input logic iv, input logic [31:0] d, input logic ordy);
      in_valid  = iv;
      in_data   = d;
      out_ready = ordy;
      @(negedge clk);
   endtask

   initial begin
      // iv, data, out_ready | exp in_ready, out_valid, out_data, fill
      vecs[0]  = mk(1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h0,        0);
      vecs[1]  = mk(1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h0,        0);
      vecs[2]  = mk(1'b1, 32'h11111111, 1'b1, 1'b1, 1'b0, 32'h0,        0);
      vecs[3]  = mk(1'b1, 32'h22222222, 1'b1, 1'b1, 1'b1, 32'h11111111, 1);
      vecs[4]  = mk(1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'h22222222, 1);
      vecs[5]  = mk(1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0,        0);
      vecs[6]  = mk(1'b1, 32'hA0,       1'b0, 1'b1, 1'b0, 32'h0,        0);
      vecs[7]  = mk(1'b1, 32'hA1,       1'b0, 1'b1, 1'b0, 32'h0,        1);
      vecs[8]  = mk(1'b1, 32'hA2,       1'b0, 1'b1, 1'b0, 32'h0,        2);
      vecs[9]  = mk(1'b1, 32'hA3,       1'b0, 1'b1, 1'b0, 32'h0,        3);
      vecs[10] = mk(1'b1, 32'hA4,       1'b1, 1'b0, 1'b0, 32'h0,        4);
      vecs[11] = mk(1'b1, 32'hA4,       1'b1, 1'b0, 1'b0, 32'h0,        4);
      vecs[12] = mk(1'b1, 32'hA4,       1'b1, 1'b0, 1'b1, 32'hA0,       4);
      vecs[13] = mk(1'b1, 32'hA4,       1'b1, 1'b1, 1'b1, 32'hA1,       3);
      vecs[14] = mk(1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'hA2,       3);
      vecs[15] = mk(1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'hA3,       2);
      vecs[16] = mk(1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'hA4,       1);
      vecs[17] = mk(1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0,        0);

      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      reset_n   = 1'b1;
      #2 reset_n = 1'b0;

      // Reset held for three cycles
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk($sformatf("rst%0d_in_ready", i),  32'(in_ready),   32'd0);
         chk($sformatf("rst%0d_out_valid", i), 32'(out_valid),  32'd0);
         chk($sformatf("rst%0d_fill", i),      32'(fill_level), 32'd0);
         chk($sformatf("rst%0d_out_data", i),  out_data,        32'd0);
      end
      reset_n = 1'b1;
      #1;
      chk("rel_in_ready",  32'(in_ready),   32'd0);
      chk("rel_out_valid", 32'(out_valid),  32'd0);
      chk("rel_fill",      32'(fill_level), 32'd0);
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b0;
      @(negedge clk);

      // Streaming and full/drain table
      for (int i = 0; i < 18; i++) begin
         chk($sformatf("v%0d_in_ready", i),  32'(in_ready),   32'(vecs[i].e_ir));
         chk($sformatf("v%0d_out_valid", i), 32'(out_valid),  32'(vecs[i].e_ov));
         chk($sformatf("v%0d_fill", i),      32'(fill_level), vecs[i].e_fill);
         if (vecs[i].e_ov) begin
            chk($sformatf("v%0d_out_data", i), out_data, vecs[i].e_data);
         end
         tick(vecs[i].iv, vecs[i].d, vecs[i].ordy);
      end

      // Single-slot ready pulse with three beats buffered
      tick(1'b1, 32'hB0, 1'b0);
      tick(1'b1, 32'hB1, 1'b0);
      tick(1'b1, 32'hB2, 1'b0);
      chk("pulse_fill_pre", 32'(fill_level), 32'd3);
      tick(1'b0, 32'h0, 1'b1);
      chk("pulse_t1_out_valid", 32'(out_valid), 32'd0);
      tick(1'b0, 32'h0, 1'b0);
      chk("pulse_t2_out_valid", 32'(out_valid), 32'd1);
      chk("pulse_t2_out_data",  out_data,       32'hB0);
      tick(1'b0, 32'h0, 1'b0);
      chk("pulse_t3_out_valid", 32'(out_valid),  32'd0);
      chk("pulse_t3_fill",      32'(fill_level), 32'd2);
      tick(1'b0, 32'h0, 1'b0);
      chk("pulse_t4_out_valid", 32'(out_valid),  32'd0);
      chk("pulse_t4_fill",      32'(fill_level), 32'd2);

      // Simultaneous push and pop at fill 2
      tick(1'b0, 32'h0, 1'b1);
      chk("pp_t1_out_valid", 32'(out_valid), 32'd0);
      tick(1'b0, 32'h0, 1'b1);
      chk("pp_t2_out_valid", 32'(out_valid),  32'd1);
      chk("pp_t2_out_data",  out_data,        32'hB1);
      chk("pp_t2_fill",      32'(fill_level), 32'd2);
      tick(1'b1, 32'h55AA55AA, 1'b1);
      chk("pp_t3_fill",      32'(fill_level), 32'd2);
      chk("pp_t3_out_valid", 32'(out_valid),  32'd1);
      chk("pp_t3_out_data",  out_data,        32'hB2);
      tick(1'b0, 32'h0, 1'b1);
      chk("pp_t4_out_valid", 32'(out_valid),  32'd1);
      chk("pp_t4_out_data",  out_data,        32'h55AA55AA);
      chk("pp_t4_fill",      32'(fill_level), 32'd1);
      tick(1'b0, 32'h0, 1'b0);
      chk("pp_t5_out_valid", 32'(out_valid),  32'd0);
      chk("pp_t5_fill",      32'(fill_level), 32'd0);
      tick(1'b0, 32'h0, 1'b0);
      tick(1'b0, 32'h0, 1'b0);

      // Reset mid-operation with three beats buffered and ready pipe full of ones
      tick(1'b1, 32'hC0, 1'b0);
      tick(1'b1, 32'hC1, 1'b0);
      tick(1'b1, 32'hC2, 1'b1);
      tick(1'b0, 32'h0, 1'b1);
      chk("mid_pre_out_valid", 32'(out_valid),  32'd1);
      chk("mid_pre_out_data",  out_data,        32'hC0);
      chk("mid_pre_fill",      32'(fill_level), 32'd3);
      reset_n   = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      #1;
      chk("mid_rst_out_valid", 32'(out_valid),  32'd0);
      chk("mid_rst_fill",      32'(fill_level), 32'd0);
      chk("mid_rst_in_ready",  32'(in_ready),   32'd0);
      chk("mid_rst_out_data",  out_data,        32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      chk("mid_rel_in_ready", 32'(in_ready), 32'd0);
      tick(1'b0, 32'h0, 1'b0);
      chk("mid_run_in_ready", 32'(in_ready), 32'd1);
      tick(1'b1, 32'hD0, 1'b0);
      chk("mid_push_fill",      32'(fill_level), 32'd1);
      chk("mid_push_out_valid", 32'(out_valid),  32'd0);
      tick(1'b0, 32'h0, 1'b0);
      chk("mid_idle_out_valid", 32'(out_valid), 32'd0);
      tick(1'b0, 32'h0, 1'b1);
      chk("mid_u1_out_valid", 32'(out_valid), 32'd0);
      tick(1'b0, 32'h0, 1'b1);
      chk("mid_u2_out_valid", 32'(out_valid), 32'd1);
      chk("mid_u2_out_data",  out_data,       32'hD0);
      tick(1'b0, 32'h0, 1'b0);
      chk("mid_u3_out_valid", 32'(out_valid),  32'd0);
      chk("mid_u3_fill",      32'(fill_level), 32'd0);

      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule
